sobel_edge: RTL and testbench
=============================

Name: sobel_edge

Overview:
- Downstream consumer of the RGB-to-YUV stage. Takes the 8-bit luma stream and its HSYNC/VSYNC/BLANK timing, computes a 3x3 Sobel gradient magnitude, and emits an edge image.
- Output is an 8-bit edge value plus RGB565 grey for the display path, with timing re-aligned to the pixel pipeline.
- Two line buffers hold the previous two lines; a 3x3 window register feeds a 3-stage arithmetic pipeline.

Parameters:
- H_ACTIVE, 640: active pixels per line; sets line-buffer depth.
- ADDR_W, 10: column counter / line-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE.
- VS_ACTIVE_LOW, 1: 1 = i_VSYNC asserted low, 0 = asserted high.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- i_HSYNC  in  1  horizontal sync, pass-through timing.
- i_VSYNC  in  1  vertical sync; its assertion edge starts a frame.
- i_BLANK  in  1  1 = active pixel (i_Y valid), 0 = blanking.
- i_Y  in  8  luma pixel.
- i_thresh  in  8  edge threshold; quasi-static, sampled every cycle.
- H_SYNC  out  1  i_HSYNC delayed 4 cycles.
- V_SYNC  out  1  i_VSYNC delayed 4 cycles.
- BLANK  out  1  i_BLANK delayed 4 cycles.
- o_edge  out  8  edge value.
- display_data  out  16  {o_edge[7:3], o_edge[7:2], o_edge[7:3]}.

Behaviour:
- Reset values:
  - All outputs 0, all sync delay registers 0.
  - Column counter 0, row counter 0, window registers 0.
  - Line-buffer contents are not reset.
- Column counter (col):
  - Increments on each cycle with i_BLANK=1.
  - Clears on the cycle after an i_BLANK 1->0 transition.
  - Saturates at H_ACTIVE-1; line-buffer writes are inhibited past H_ACTIVE pixels.
- Row counter (row):
  - Increments on each i_BLANK 1->0 transition; saturates at 2.
  - Clears on the VSYNC assertion edge. This edge takes priority if it coincides with a line end.
- Stage 0 (valid pixel):
  - Read lb1[col] (line n-1) and lb2[col] (line n-2).
  - Write i_Y to lb1[col] and the old lb1[col] to lb2[col] (read-before-write).
  - Shift the window columns left; the new right column is {lb2, lb1, i_Y}.
- Stage 1: Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20), and Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02). Both are 11-bit signed, range ±1020.
- Stage 2: mag = |Gx| + |Gy|, 11-bit unsigned, max 2040.
- Stage 3: o_edge is produced per the Optional Feature.
- Border and blanking:
  - The border flag is (row < 2) or (col < 2), captured at stage 0 and pipelined alongside the data.
  - Border pixels and blanking pixels force o_edge = 0.
- Latency: 4 cycles from an i_Y / sync sample to o_edge / sync out. The result at output pixel (r, c) is the window centred on input (r−1, c−1), i.e. a fixed 1-line, 1-pixel image offset.
- Window registers do not shift during blanking, so a new line starts from a stale window. The col < 2 border flag masks this.
- Reset mid-frame:
  - Everything restarts.
  - Output stays 0 until two full lines have been seen after the next VSYNC assertion edge, because row clears there.
- Short lines: a line with fewer than H_ACTIVE pixels leaves unwritten entries stale. These are used only at cols that do not occur again. No error is raised.

Optional Feature:
- Macro SOBEL_BINARY_EN.
- Defined: o_edge = 8'hFF if mag >= {3'b0, i_thresh}, else 8'h00.
- Undefined: o_edge = min(mag, 255) (saturating); i_thresh is ignored.
- Latency is identical in both builds.

Decomposition:
- Package sobel_pkg holds:
  - PIX_W = 8, GRAD_W = 11, MAG_W = 11, PIPE_LAT = 4.
  - typedef pix_t (8-bit unsigned), grad_t (11-bit signed), mag_t (11-bit unsigned).
- Sub-module line_buffer: a simple dual-port RAM with depth H_ACTIVE and width 8.
  - Synchronous read with read-before-write on the same address.
  - Instantiated twice.

Test Plan:
- Flat image, all i_Y = 8'h80, 640x480 → o_edge = 0 everywhere; H_SYNC/V_SYNC/BLANK equal the inputs delayed exactly 4 cycles.
- Vertical step: cols < 100 = 0, cols >= 100 = 255.
  - Undefined build: output rows ≥ 2 show o_edge = 255 at output cols 100 and 101 (mag 1020), 0 elsewhere.
  - SOBEL_BINARY_EN build: i_thresh = 200 gives 8'hFF at those columns.
- Horizontal step: rows < 50 = 0, rows >= 50 = 40.
  - Output rows 50 and 51 give mag = 160.
  - Undefined build: o_edge = 160.
  - SOBEL_BINARY_EN build: i_thresh = 161 gives 0; i_thresh = 160 gives 8'hFF.
- Border masking: random image → output rows 0–1 and cols 0–1 of every line are 0 for all frames.
- Reset: assert rst_n low at line 200 for 3 cycles → all outputs 0 immediately; o_edge stays 0 until row ≥ 2 after the next VSYNC assertion edge, then matches a reference model.
- Line longer than H_ACTIVE: 700 valid pixels → no address wrap; columns 0–639 of the next line compute correctly against the reference model.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, pipeline depth and pixel/gradient types for the Sobel edge stage.
package sobel_pkg;
  localparam int PIX_W    = 8;
  localparam int GRAD_W   = 11;
  localparam int MAG_W    = 11;
  localparam int PIPE_LAT = 4;

  typedef logic        [PIX_W-1:0]  pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic        [MAG_W-1:0]  mag_t;

  // |g| for a gradient bounded to +/-1020, so negation never overflows
  function automatic mag_t abs_grad(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One video line of luma: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output pix_t              rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pix_t              wdata
);
  pix_t mem [DEPTH];

  // storage write; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read, held while re is low so it can act as a window column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sobel_edge.sv
// 3x3 Sobel gradient magnitude on the luma stream, 4-cycle latency, with
// timing passed through the same delay. Output (r,c) is centred on input (r-1,c-1).
// Build option: define SOBEL_BINARY_EN for a thresholded 0/FF output instead of
// the saturated magnitude.
module sobel_edge
  import sobel_pkg::*;
#(
  parameter int H_ACTIVE      = 640,
  parameter int ADDR_W        = 10,
  parameter bit VS_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_HSYNC,
  input  logic        i_VSYNC,
  input  logic        i_BLANK,
  input  logic [7:0]  i_Y,
  input  logic [7:0]  i_thresh,
  output logic        H_SYNC,
  output logic        V_SYNC,
  output logic        BLANK,
  output logic [7:0]  o_edge,
  output logic [15:0] display_data
);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(H_ACTIVE - 1);

  logic              blank_q, vs_q, frame_ok, col_full, lb_we, we_q;
  logic [ADDR_W-1:0] col, col_q;
  logic [1:0]        row;
  logic              vs_act, vs_edge, line_end, stage0_ok;

  assign vs_act    = VS_ACTIVE_LOW ? ~i_VSYNC : i_VSYNC;
  assign vs_edge   = vs_act & ~vs_q;
  assign line_end  = blank_q & ~i_BLANK;
  assign lb_we     = i_BLANK & ~col_full;
  // frame_ok holds the output off after reset until a fresh frame starts, so a
  // mid-frame reset never shows partial-frame gradients
  assign stage0_ok = i_BLANK & frame_ok & (row == 2'd2) & (col >= ADDR_W'(2));

  // column/row position tracking and frame start detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q  <= 1'b0;
      vs_q     <= 1'b0;
      frame_ok <= 1'b0;
      row      <= '0;
      col      <= '0;
      col_full <= 1'b0;
      col_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      blank_q <= i_BLANK;
      vs_q    <= vs_act;
      col_q   <= col;
      we_q    <= lb_we;
      if (vs_edge) frame_ok <= 1'b1;
      if (vs_edge)                      row <= '0;
      else if (line_end && row != 2'd2) row <= row + 2'd1;
      if (line_end) begin
        col      <= '0;
        col_full <= 1'b0;
      end else if (i_BLANK) begin
        if (col == COL_MAX) col_full <= 1'b1;  // later pixels must not overwrite
        else                col <= col + 1'b1;
      end
    end
  end

  // lb1 = line n-1, lb2 = line n-2. lb2 takes lb1's old value one cycle later,
  // once the registered read of lb1 has it.
  pix_t lb1_rd, lb2_rd;

  line_buffer #(.DEPTH(H_ACTIVE), .ADDR_W(ADDR_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .re(i_BLANK), .raddr(col), .rdata(lb1_rd),
    .we(lb_we), .waddr(col), .wdata(i_Y)
  );

  line_buffer #(.DEPTH(H_ACTIVE), .ADDR_W(ADDR_W)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .re(i_BLANK), .raddr(col), .rdata(lb2_rd),
    .we(we_q), .waddr(col_q), .wdata(lb1_rd)
  );

  // window: columns 0/1 are registers, column 2 is {lb2_rd, lb1_rd, y_q}
  pix_t p00, p01, p10, p11, p20, p21, y_q;
  pix_t p02, p12, p22;
  assign p02 = lb2_rd;
  assign p12 = lb1_rd;
  assign p22 = y_q;

  // shift window left on active pixels only; frozen through blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {p00, p01, p10, p11, p20, p21, y_q} <= '0;
    end else if (i_BLANK) begin
      p00 <= p01;  p01 <= p02;
      p10 <= p11;  p11 <= p12;
      p20 <= p21;  p21 <= p22;
      y_q <= i_Y;
    end
  end

  // weighted column/row sums, each at most 4*255 = 1020
  logic [9:0] sx_r, sx_l, sy_b, sy_t;
  assign sx_r = {2'b0, p02} + {1'b0, p12, 1'b0} + {2'b0, p22};
  assign sx_l = {2'b0, p00} + {1'b0, p10, 1'b0} + {2'b0, p20};
  assign sy_b = {2'b0, p20} + {1'b0, p21, 1'b0} + {2'b0, p22};
  assign sy_t = {2'b0, p00} + {1'b0, p01, 1'b0} + {2'b0, p02};

  grad_t gx, gy;
  mag_t  mag;
  logic [7:0] edge_c;

`ifdef SOBEL_BINARY_EN
  assign edge_c = (mag >= {3'b0, i_thresh}) ? 8'hFF : 8'h00;
`else
  logic unused_thresh;
  assign unused_thresh = ^i_thresh;
  assign edge_c = (mag > mag_t'(255)) ? 8'hFF : mag[7:0];
`endif

  logic [PIPE_LAT-2:0]        vld_pipe;
  logic [PIPE_LAT-1:0][2:0]   sync_pipe;

  // gradient -> magnitude -> output stages, with the not-masked flag and
  // timing travelling alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx        <= '0;
      gy        <= '0;
      mag       <= '0;
      o_edge    <= '0;
      vld_pipe  <= '0;
      sync_pipe <= '0;
    end else begin
      gx        <= grad_t'({1'b0, sx_r}) - grad_t'({1'b0, sx_l});
      gy        <= grad_t'({1'b0, sy_b}) - grad_t'({1'b0, sy_t});
      mag       <= abs_grad(gx) + abs_grad(gy);
      o_edge    <= vld_pipe[PIPE_LAT-2] ? edge_c : 8'h00;
      vld_pipe  <= {vld_pipe[PIPE_LAT-3:0], stage0_ok};
      sync_pipe <= {sync_pipe[PIPE_LAT-2:0], i_HSYNC, i_VSYNC, i_BLANK};
    end
  end

  assign {H_SYNC, V_SYNC, BLANK} = sync_pipe[PIPE_LAT-1];
  assign display_data = {o_edge[7:3], o_edge[7:2], o_edge[7:3]};
endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge on a 12-pixel-wide image.
module tb_sobel_edge;
  localparam int H = 12;
  localparam int FLAT = 0, VSTEP = 1, HSTEP = 2, RAND = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_HSYNC = 1'b1, i_VSYNC = 1'b1, i_BLANK = 1'b0;
  logic [7:0]  i_Y = '0, i_thresh = 8'd200;
  logic        H_SYNC, V_SYNC, BLANK;
  logic [7:0]  o_edge;
  logic [15:0] display_data;

  sobel_edge #(.H_ACTIVE(H), .ADDR_W(4), .VS_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_HSYNC(i_HSYNC), .i_VSYNC(i_VSYNC),
    .i_BLANK(i_BLANK), .i_Y(i_Y), .i_thresh(i_thresh), .H_SYNC(H_SYNC),
    .V_SYNC(V_SYNC), .BLANK(BLANK), .o_edge(o_edge), .display_data(display_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hs; logic vs; logic bl; logic chk; logic [7:0] ex;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  int   img [0:15][0:H-1];
  int   cur_row = 0;
  bit   model_ok = 1'b0;

  function automatic logic [7:0] edge_of(input int mag);
`ifdef SOBEL_BINARY_EN
    return (mag >= int'(i_thresh)) ? 8'hFF : 8'h00;
`else
    return (mag > 255) ? 8'hFF : 8'(mag);
`endif
  endfunction

  // reference Sobel on the stored image, window rows r-2..r, cols c-2..c
  function automatic int model_mag(input int r, input int c);
    int p [3][3];
    int gx, gy;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) p[i][j] = img[r-2+i][c-2+j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    case (mode)
      FLAT:    return 8'h80;
      VSTEP:   return (c < 5) ? 8'd0 : 8'd255;
      HSTEP:   return (r < 4) ? 8'd0 : 8'd40;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // hand-derived magnitudes for the step images; model for random ones
  function automatic logic [7:0] expected(input int mode, input int r, input int c);
    int mag;
    if (!model_ok || r < 2 || c < 2) return 8'h00;
    case (mode)
      FLAT:    mag = 0;
      VSTEP:   mag = (c == 5 || c == 6) ? 1020 : 0;
      HSTEP:   mag = (r == 4 || r == 5) ? 160 : 0;
      default: mag = model_mag(r, c);
    endcase
    return edge_of(mag);
  endfunction

  task automatic check_out();
    exp_t e;
    logic [15:0] d;
    e = q.pop_front();
    d = {e.ex[7:3], e.ex[7:2], e.ex[7:3]};
    checks++;
    assert (H_SYNC === e.hs) else begin
      errors++; $error("FAIL h_sync: observed %b expected %b", H_SYNC, e.hs);
    end
    checks++;
    assert (V_SYNC === e.vs) else begin
      errors++; $error("FAIL v_sync: observed %b expected %b", V_SYNC, e.vs);
    end
    checks++;
    assert (BLANK === e.bl) else begin
      errors++; $error("FAIL blank: observed %b expected %b", BLANK, e.bl);
    end
    if (e.chk) begin
      checks++;
      assert (o_edge === e.ex) else begin
        errors++; $error("FAIL o_edge: observed %h expected %h", o_edge, e.ex);
      end
      checks++;
      assert (display_data === d) else begin
        errors++; $error("FAIL display: observed %h expected %h", display_data, d);
      end
    end
  endtask

  // one pixel clock: check the result due now, then drive the next inputs
  task automatic cyc(input logic hs, input logic vs, input logic bl,
                     input logic [7:0] y, input logic chk, input logic [7:0] ex);
    exp_t e;
    @(negedge clk);
    if (q.size() >= 4) check_out();
    i_HSYNC = hs; i_VSYNC = vs; i_BLANK = bl; i_Y = y;
    e.hs = hs; e.vs = vs; e.bl = bl; e.chk = chk; e.ex = ex;
    q.push_back(e);
  endtask

  task automatic pixel(input int mode, input int c);
    logic [7:0] y;
    y = pix(mode, cur_row, c);
    if (c < H) img[cur_row][c] = int'(y);
    cyc(1'b1, 1'b1, 1'b1, y, c < H, (c < H) ? expected(mode, cur_row, c) : 8'h00);
  endtask

  task automatic line(input int mode, input int len);
    for (int c = 0; c < len; c++) pixel(mode, c);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    cur_row++;
  endtask

  task automatic frame_start();
    model_ok = 1'b1;
    cur_row  = 0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
  endtask

  task automatic frame(input int mode, input int nrows);
    frame_start();
    for (int r = 0; r < nrows; r++) line(mode, H);
  endtask

  // reset for 3 clocks; outputs must drop at once, then the pipeline refills
  task automatic do_reset();
    exp_t z;
    @(negedge clk);
    rst_n = 1'b0;
    i_HSYNC = 1'b1; i_VSYNC = 1'b1; i_BLANK = 1'b0; i_Y = '0;
    #1;
    checks++;
    assert ({H_SYNC, V_SYNC, BLANK} === 3'b000) else begin
      errors++; $error("FAIL rst_sync: observed %b expected 000", {H_SYNC, V_SYNC, BLANK});
    end
    checks++;
    assert (o_edge === 8'h00) else begin
      errors++; $error("FAIL rst_edge: observed %h expected 00", o_edge);
    end
    checks++;
    assert (display_data === 16'h0000) else begin
      errors++; $error("FAIL rst_display: observed %h expected 0000", display_data);
    end
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    model_ok = 1'b0;
    q.delete();
    z = '0; z.chk = 1'b1;
    repeat (3) q.push_back(z);
    z.hs = 1'b1; z.vs = 1'b1;
    q.push_back(z);
  endtask

  initial begin
    do_reset();

    // flat image: no edges, timing delayed by exactly 4
    frame(FLAT, 6);

    // vertical step at col 5: full-scale edge at output cols 5 and 6
    i_thresh = 8'd200;
    frame(VSTEP, 5);

    // horizontal step at row 4: magnitude 160 on output rows 4 and 5
    i_thresh = 8'd161;
    frame(HSTEP, 8);
    i_thresh = 8'd160;
    frame(HSTEP, 8);

    // random image: borders masked, interior against the model
    i_thresh = 8'd100;
    frame(RAND, 6);

    // mid-frame reset: output held at 0 until the next frame has 2 lines
    frame_start();
    for (int r = 0; r < 3; r++) line(RAND, H);
    for (int c = 0; c < 5; c++) pixel(RAND, c);
    do_reset();
    cur_row = 4;
    for (int r = 0; r < 3; r++) line(RAND, H);
    frame(RAND, 5);

    // over-long line: later lines still see correct line-buffer contents
    frame_start();
    line(RAND, H);
    line(RAND, H);
    line(RAND, H + 2);
    line(RAND, H);
    line(RAND, H);

    repeat (4) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
